// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART RX framer.
//   state_e        : frame FSM states (IDLE, DATA, PARITY, STOP)
//   PAR_EVEN/ODD   : encoding of the PAR_TYP input
//   DATA_WIDTH_MIN/MAX : legal range for the data width parameter
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational expected-parity generator, shared by the
// RX deserializer and the TX serializer.
//   data_i [WIDTH] : data word
//   typ_i          : PAR_EVEN / PAR_ODD
//   par_o          : parity bit a correct frame carries for data_i
module uart_parity_calc
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             typ_i,
    output logic             par_o
);

    // Even parity: bit makes the total count of ones even; odd inverts it.
    assign par_o = (typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule

// File: rtl/uart_rx_frame_deser.sv
// uart_rx_frame_deser: UART receive framer / deserializer.
// Consumes one voted bit per bit_strobe, walks start/data/parity/stop,
// and on frame completion emits registered one-cycle pulses.
//   CLK, RST (async, active-low)
//   bit_strobe, sampled_bit : bit from the RX sampler
//   PAR_EN, PAR_TYP         : parity config, latched at each start bit
//   P_DATA      : last good word, held
//   DATA_VALID  : pulse, P_DATA updated
//   PAR_ERR     : pulse, parity mismatch
//   STP_ERR     : pulse, a stop bit sampled low
//   busy        : frame in progress
// Optional build macro UART_RX_FRAME_DESER_MSB_FIRST_EN: data arrives
// MSB-first (first data bit lands in P_DATA[DATA_WIDTH-1]).
module uart_rx_frame_deser
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  bit_strobe,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_in;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  cfg_en_q, cfg_en_d;
    logic                  cfg_typ_q, cfg_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic                  stp_bad_q, stp_bad_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  dv_q, dv_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  busy_q, busy_d;
    logic                  exp_par;
    logic                  stp_fin;

`ifdef UART_RX_FRAME_DESER_MSB_FIRST_EN
    assign shift_in = {shift_q[DATA_WIDTH-2:0], sampled_bit};
`else
    assign shift_in = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
`endif

    uart_parity_calc #(.WIDTH(DATA_WIDTH)) u_par (
        .data_i (shift_q),
        .typ_i  (cfg_typ_q),
        .par_o  (exp_par)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        cfg_en_d  = cfg_en_q;
        cfg_typ_d = cfg_typ_q;
        par_bad_d = par_bad_q;
        stp_bad_d = stp_bad_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        stp_fin   = stp_bad_q | ~sampled_bit;

        if (bit_strobe) begin
            case (state_q)
                IDLE: begin
                    if (!sampled_bit) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        cfg_en_d  = PAR_EN;
                        cfg_typ_d = PAR_TYP;
                        par_bad_d = 1'b0;
                        stp_bad_d = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = shift_in;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = cfg_en_q ? PARITY : STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PARITY: begin
                    par_bad_d = (sampled_bit != exp_par);
                    state_d   = STOP;
                end
                STOP: begin
                    stp_bad_d = stp_fin;
                    if (cnt_q == STOP_LAST) begin
                        // Frame completes on this edge; pulses show next cycle.
                        state_d = IDLE;
                        cnt_d   = '0;
                        perr_d  = par_bad_q;
                        serr_d  = stp_fin;
                        if (!par_bad_q && !stp_fin) begin
                            dv_d    = 1'b1;
                            pdata_d = shift_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            cfg_en_q  <= 1'b0;
            cfg_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            stp_bad_q <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            cfg_en_q  <= cfg_en_d;
            cfg_typ_q <= cfg_typ_d;
            par_bad_q <= par_bad_d;
            stp_bad_q <= stp_bad_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
            busy_q    <= busy_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = perr_q;
    assign STP_ERR    = serr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_deser.sv
// tb_uart_rx_frame_deser: directed plus randomized frames against a
// frame-level reference model (expected word/flags from the frame contents).
module tb_uart_rx_frame_deser;

    logic       CLK = 1'b0;
    logic       RST;
    logic       bit_strobe;
    logic       sampled_bit;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       busy;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] pd_model = 8'h00;

    always #5 CLK = ~CLK;

    uart_rx_frame_deser #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bit_strobe  (bit_strobe),
        .sampled_bit (sampled_bit),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .P_DATA      (P_DATA),
        .DATA_VALID  (DATA_VALID),
        .PAR_ERR     (PAR_ERR),
        .STP_ERR     (STP_ERR),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic strobe(input logic b);
        bit_strobe  = 1'b1;
        sampled_bit = b;
        @(negedge CLK);
        bit_strobe  = 1'b0;
    endtask

    task automatic idle(input int g);
        repeat (g) begin
            sampled_bit = 1'($urandom);
            @(negedge CLK);
        end
    endtask

    // Parity bit a correct frame carries: total ones even (typ 0) or odd (typ 1).
    function automatic logic good_par(input logic [7:0] d, input logic typ);
        return logic'(($countones(d) + int'(typ)) % 2);
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic en, input logic typ,
                              input logic pbit, input logic sbit,
                              input logic [1:0] flip, input int gap);
        PAR_EN  = en;
        PAR_TYP = typ;
        strobe(1'b0);
        chk("busy_after_start", 16'(busy), 16'd1);
        if (flip[0]) PAR_TYP = ~typ;
        if (flip[1]) PAR_EN  = ~en;
        idle(gap);
        for (int i = 0; i < 8; i++) begin
            strobe(d[i]);
            idle(gap);
        end
        if (en) begin
            strobe(pbit);
            idle(gap);
        end
        strobe(sbit);
    endtask

    // Model the frame outcome and compare on the completion cycle.
    task automatic check_frame(input string tag, input logic [7:0] d, input logic en,
                               input logic typ, input logic pbit, input logic sbit);
        logic pe, se, dv;
        pe = en && (pbit != good_par(d, typ));
        se = !sbit;
        dv = !pe && !se;
        if (dv) pd_model = d;
        chk({tag, ".valid"}, 16'(DATA_VALID), 16'(dv));
        chk({tag, ".par_err"}, 16'(PAR_ERR), 16'(pe));
        chk({tag, ".stp_err"}, 16'(STP_ERR), 16'(se));
        chk({tag, ".p_data"}, 16'(P_DATA), 16'(pd_model));
        chk({tag, ".busy"}, 16'(busy), 16'd0);
    endtask

    task automatic after_pulse(input string tag);
        @(negedge CLK);
        chk({tag, ".valid_end"}, 16'(DATA_VALID), 16'd0);
        chk({tag, ".perr_end"}, 16'(PAR_ERR), 16'd0);
        chk({tag, ".serr_end"}, 16'(STP_ERR), 16'd0);
        chk({tag, ".p_data_hold"}, 16'(P_DATA), 16'(pd_model));
    endtask

    initial begin
        RST = 1'b0; bit_strobe = 1'b0; sampled_bit = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst.p_data", 16'(P_DATA), 16'h0);
        chk("rst.valid", 16'(DATA_VALID), 16'd0);
        chk("rst.perr", 16'(PAR_ERR), 16'd0);
        chk("rst.serr", 16'(STP_ERR), 16'd0);
        chk("rst.busy", 16'(busy), 16'd0);
        RST = 1'b1;
        idle(2);

        // idle-line strobes (high) must not start a frame
        strobe(1'b1);
        strobe(1'b1);
        chk("idle_high.busy", 16'(busy), 16'd0);

        // 1: 0xA5 even parity, good
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1);
        check_frame("t1", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        after_pulse("t1");
        // 2: same frame, bad parity
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1);
        check_frame("t2", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        after_pulse("t2");
        // 3: no parity, stop low, then a good 0x81
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0);
        check_frame("t3a", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        after_pulse("t3a");
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 0);
        check_frame("t3b", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        after_pulse("t3b");
        // 4: back-to-back, second start strobe on the completion cycle
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 0);
        check_frame("t4a", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 0);
        check_frame("t4b", 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        after_pulse("t4b");
        // 5: reset after 4 data bits, then 0x0F
        PAR_EN = 1'b0;
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        RST = 1'b0;
        #1;
        pd_model = 8'h00;
        chk("t5.rst_p_data", 16'(P_DATA), 16'h0);
        chk("t5.rst_busy", 16'(busy), 16'd0);
        chk("t5.rst_valid", 16'(DATA_VALID), 16'd0);
        @(negedge CLK);
        RST = 1'b1;
        idle(1);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 0);
        check_frame("t5", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        after_pulse("t5");
        // 6: PAR_TYP flips mid-frame; frame uses latched even parity
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 0);
        check_frame("t6", 8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        after_pulse("t6");

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       en, typ, pbit, sbit;
            logic [1:0] err, flip;
            int         gap, igap;
            d    = 8'($urandom);
            en   = 1'($urandom);
            typ  = 1'($urandom);
            err  = 2'($urandom_range(0, 3));
            flip = 2'($urandom);
            gap  = $urandom_range(0, 2);
            igap = $urandom_range(0, 2);
            pbit = good_par(d, typ) ^ err[0];
            sbit = ~err[1];
            send_frame(d, en, typ, pbit, sbit, flip, gap);
            check_frame("rnd", d, en, typ, pbit, sbit);
            if (igap > 0) begin
                after_pulse("rnd");
                idle(igap - 1);
            end
        end
        after_pulse("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
